// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg
//   Shared definitions for the SRAM access controller in the MEM stage:
//   reset levels, memory request codes, register write-enable levels,
//   FSM state encoding and the default strobe width.
package mem_sram_ctrl_pkg;

   localparam logic RstEnable  = 1'b0;
   localparam logic RstDisable = 1'b1;

   localparam logic [1:0] MemRW_Idle  = 2'b00;
   localparam logic [1:0] MemRW_Read  = 2'b01;
   localparam logic [1:0] MemRW_Write = 2'b10;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   localparam int unsigned WAIT_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_DONE = 2'b11
   } sram_state_t;

endpackage

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl
//   MEM-stage controller for an asynchronous 16-bit SRAM. A read or write
//   request from ex_mem holds the pipeline while the active-low strobes are
//   held low for WAIT_CYCLES clocks; a one-cycle DONE state then releases
//   the stall and, after a read, presents the captured data to write-back.
//   Non-memory instructions pass straight through with no stall.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   mem_memrw                request code (Idle/Read/Write; 2'b11 = Idle)
//   mem_memaddr, mem_memdata word address and store data
//   mem_wdata/waddr/we       ALU result, destination register, write enable
//   wb_wdata/waddr/we        write-back bus
//   stall_req                pipeline hold request
//   ram_addr, ram_dout       SRAM address and store data (registered)
//   ram_doe                  drive ram_dout onto the SRAM data bus
//   ram_din                  SRAM read data
//   ram_ce_n/oe_n/we_n       active-low SRAM strobes (registered)
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mem_memrw,
   input  logic [15:0] mem_memaddr,
   input  logic [15:0] mem_memdata,
   input  logic [15:0] mem_wdata,
   input  logic [3:0]  mem_waddr,
   input  logic        mem_we,
   output logic [15:0] wb_wdata,
   output logic [3:0]  wb_waddr,
   output logic        wb_we,
   output logic        stall_req,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_dout,
   output logic        ram_doe,
   input  logic [15:0] ram_din,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   localparam logic [1:0] CNT_LOAD = 2'(WAIT_CYCLES - 1);

   sram_state_t r_state;
   logic [1:0]  r_cnt;
   logic [15:0] r_rdata;
   logic        r_was_rd;   // last access was a read; selects rdata in DONE
   logic [15:0] r_ram_addr;
   logic [15:0] r_ram_dout;
   logic        r_ram_doe;
   logic        r_ram_ce_n;
   logic        r_ram_oe_n;
   logic        r_ram_we_n;

   logic        w_req_rd;
   logic        w_req_wr;
   logic        w_in_rst;
   logic        w_stall;

   assign w_req_rd = (mem_memrw == MemRW_Read);
   assign w_req_wr = (mem_memrw == MemRW_Write);
   assign w_in_rst = (rst == RstEnable);

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_was_rd   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_dout <= '0;
         r_ram_doe  <= 1'b0;
         r_ram_ce_n <= 1'b1;
         r_ram_oe_n <= 1'b1;
         r_ram_we_n <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_rd) begin
                  r_ram_addr <= mem_memaddr;
                  r_ram_ce_n <= 1'b0;
                  r_ram_oe_n <= 1'b0;
                  r_cnt      <= CNT_LOAD;
                  r_was_rd   <= 1'b1;
                  r_state    <= ST_RD;
               end else if (w_req_wr) begin
                  r_ram_addr <= mem_memaddr;
                  r_ram_dout <= mem_memdata;
                  r_ram_doe  <= 1'b1;
                  r_ram_ce_n <= 1'b0;
                  r_ram_we_n <= 1'b0;
                  r_cnt      <= CNT_LOAD;
                  r_was_rd   <= 1'b0;
                  r_state    <= ST_WR;
               end
            end
            ST_RD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  r_rdata    <= ram_din;
                  r_ram_ce_n <= 1'b1;
                  r_ram_oe_n <= 1'b1;
                  r_ram_we_n <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_WR: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  // ram_doe and ram_addr stay put through DONE for hold time
                  r_ram_we_n <= 1'b1;
                  r_ram_ce_n <= 1'b1;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ram_doe <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_stall = 1'b0;
      if (!w_in_rst) begin
         w_stall = ((r_state == ST_IDLE) && (w_req_rd || w_req_wr)) ||
                   (r_state == ST_RD) || (r_state == ST_WR);
      end
   end

   assign stall_req = w_stall;
   assign wb_waddr  = mem_waddr;
   assign wb_we     = w_in_rst ? WriteDisable : (mem_we & ~w_stall);
   assign wb_wdata  = ((r_state == ST_DONE) && r_was_rd) ? r_rdata : mem_wdata;

   assign ram_addr = r_ram_addr;
   assign ram_dout = r_ram_dout;
   assign ram_doe  = r_ram_doe;
   assign ram_ce_n = r_ram_ce_n;
   assign ram_oe_n = r_ram_oe_n;
   assign ram_we_n = r_ram_we_n;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl
//   Directed-vector bench for mem_sram_ctrl with WAIT_CYCLES = 2. Inputs are
//   changed and outputs sampled 1 time unit after each rising edge; a
//   mid-cycle monitor watches strobe exclusivity and chip-enable spacing
//   during the back-to-back sequence.
module tb_mem_sram_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  mem_memrw;
   logic [15:0] mem_memaddr;
   logic [15:0] mem_memdata;
   logic [15:0] mem_wdata;
   logic [3:0]  mem_waddr;
   logic        mem_we;
   logic [15:0] wb_wdata;
   logic [3:0]  wb_waddr;
   logic        wb_we;
   logic        stall_req;
   logic [15:0] ram_addr;
   logic [15:0] ram_dout;
   logic        ram_doe;
   logic [15:0] ram_din;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;

   int unsigned n_vec;
   int unsigned n_err;

   logic        mon_en;
   int unsigned ce_hi_run;
   logic        ce_seen;

   mem_sram_ctrl #(.WAIT_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_memrw   (mem_memrw),
      .mem_memaddr (mem_memaddr),
      .mem_memdata (mem_memdata),
      .mem_wdata   (mem_wdata),
      .mem_waddr   (mem_waddr),
      .mem_we      (mem_we),
      .wb_wdata    (wb_wdata),
      .wb_waddr    (wb_waddr),
      .wb_we       (wb_we),
      .stall_req   (stall_req),
      .ram_addr    (ram_addr),
      .ram_dout    (ram_dout),
      .ram_doe     (ram_doe),
      .ram_din     (ram_din),
      .ram_ce_n    (ram_ce_n),
      .ram_oe_n    (ram_oe_n),
      .ram_we_n    (ram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe exclusivity and ce_n high-gap monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("we_oe_excl", {31'd0, (ram_we_n | ram_oe_n)}, 32'd1);
         if (ram_ce_n) begin
            ce_hi_run++;
         end else begin
            if (ce_seen && ce_hi_run != 0)
               chk("ce_gap_ge2", {31'd0, (ce_hi_run >= 2)}, 32'd1);
            ce_seen   = 1'b1;
            ce_hi_run = 0;
         end
      end
   end

   initial begin
      n_vec = 0; n_err = 0;
      mon_en = 1'b0; ce_hi_run = 0; ce_seen = 1'b0;
      rst = 1'b0; mem_memrw = 2'b01; mem_memaddr = 16'h0007; mem_memdata = 16'h0;
      mem_wdata = 16'h0; mem_waddr = 4'h0; mem_we = 1'b1; ram_din = 16'h0;

      // Reset with a read request present
      tick(); tick();
      chk("rst_ce_n",  {31'd0, ram_ce_n}, 32'd1);
      chk("rst_oe_n",  {31'd0, ram_oe_n}, 32'd1);
      chk("rst_we_n",  {31'd0, ram_we_n}, 32'd1);
      chk("rst_doe",   {31'd0, ram_doe},  32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_wb_we", {31'd0, wb_we},    32'd0);
      chk("rst_addr",  {16'd0, ram_addr}, 32'h0);

      // Pass-through
      rst = 1'b1; mem_memrw = 2'b00; mem_wdata = 16'h0001; mem_waddr = 4'h1; mem_we = 1'b1;
      #1;
      chk("pt_wdata", {16'd0, wb_wdata}, 32'h1);
      chk("pt_waddr", {28'd0, wb_waddr}, 32'h1);
      chk("pt_we",    {31'd0, wb_we},    32'd1);
      chk("pt_stall", {31'd0, stall_req}, 32'd0);
      mem_memrw = 2'b11;
      #1;
      chk("code11_stall", {31'd0, stall_req}, 32'd0);

      // Write 0x0002 -> 0x0002
      mem_memrw = 2'b10; mem_memaddr = 16'h0002; mem_memdata = 16'h0002; mem_we = 1'b0;
      #1;
      chk("wr_stall0", {31'd0, stall_req}, 32'd1);
      tick();
      chk("wr1_stall", {31'd0, stall_req}, 32'd1);
      chk("wr1_we_n",  {31'd0, ram_we_n},  32'd0);
      chk("wr1_ce_n",  {31'd0, ram_ce_n},  32'd0);
      chk("wr1_oe_n",  {31'd0, ram_oe_n},  32'd1);
      chk("wr1_addr",  {16'd0, ram_addr},  32'h2);
      chk("wr1_dout",  {16'd0, ram_dout},  32'h2);
      chk("wr1_doe",   {31'd0, ram_doe},   32'd1);
      mem_memaddr = 16'hFFFF; mem_memdata = 16'hFFFF;
      tick();
      chk("wr2_stall", {31'd0, stall_req}, 32'd1);
      chk("wr2_we_n",  {31'd0, ram_we_n},  32'd0);
      chk("wr2_addr",  {16'd0, ram_addr},  32'h2);
      chk("wr2_dout",  {16'd0, ram_dout},  32'h2);
      tick();
      chk("wrd_stall", {31'd0, stall_req}, 32'd0);
      chk("wrd_we_n",  {31'd0, ram_we_n},  32'd1);
      chk("wrd_ce_n",  {31'd0, ram_ce_n},  32'd1);
      chk("wrd_doe",   {31'd0, ram_doe},   32'd1);
      chk("wrd_addr",  {16'd0, ram_addr},  32'h2);
      tick();
      // DONE ignored the still-present write request
      chk("wri_ce_n",  {31'd0, ram_ce_n},  32'd1);
      chk("wri_we_n",  {31'd0, ram_we_n},  32'd1);
      chk("wri_doe",   {31'd0, ram_doe},   32'd0);
      mem_memrw = 2'b00;
      #1;
      chk("wri_stall", {31'd0, stall_req}, 32'd0);

      // Read 0x0002 returning 0x1234
      mem_memrw = 2'b01; mem_memaddr = 16'h0002; ram_din = 16'h1234;
      mem_wdata = 16'h5555; mem_waddr = 4'h1; mem_we = 1'b1;
      #1;
      chk("rd0_stall", {31'd0, stall_req}, 32'd1);
      chk("rd0_wb_we", {31'd0, wb_we},     32'd0);
      tick();
      chk("rd1_ce_n",  {31'd0, ram_ce_n},  32'd0);
      chk("rd1_oe_n",  {31'd0, ram_oe_n},  32'd0);
      chk("rd1_we_n",  {31'd0, ram_we_n},  32'd1);
      chk("rd1_addr",  {16'd0, ram_addr},  32'h2);
      chk("rd1_wb_we", {31'd0, wb_we},     32'd0);
      tick();
      chk("rd2_oe_n",  {31'd0, ram_oe_n},  32'd0);
      chk("rd2_stall", {31'd0, stall_req}, 32'd1);
      chk("rd2_wdata", {16'd0, wb_wdata},  32'h5555);
      tick();
      chk("rdd_oe_n",  {31'd0, ram_oe_n},  32'd1);
      chk("rdd_ce_n",  {31'd0, ram_ce_n},  32'd1);
      chk("rdd_stall", {31'd0, stall_req}, 32'd0);
      chk("rdd_wdata", {16'd0, wb_wdata},  32'h1234);
      chk("rdd_waddr", {28'd0, wb_waddr},  32'h1);
      chk("rdd_wb_we", {31'd0, wb_we},     32'd1);
      mem_memrw = 2'b00;
      tick();
      chk("rdi_wdata", {16'd0, wb_wdata},  32'h5555);
      chk("rdi_wb_we", {31'd0, wb_we},     32'd1);

      // Reset during the second RD cycle
      mem_memrw = 2'b01; mem_memaddr = 16'h0003; ram_din = 16'hBEEF;
      tick();
      tick();
      chk("mr_rd2_oe_n", {31'd0, ram_oe_n}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mr_stall_rst", {31'd0, stall_req}, 32'd0);
      tick();
      chk("mr_ce_n",  {31'd0, ram_ce_n},  32'd1);
      chk("mr_oe_n",  {31'd0, ram_oe_n},  32'd1);
      chk("mr_stall", {31'd0, stall_req}, 32'd0);
      chk("mr_rdata", {16'd0, dut.r_rdata}, 32'h0);
      rst = 1'b1; mem_memrw = 2'b00;
      #1;
      chk("mr_idle_stall", {31'd0, stall_req}, 32'd0);
      chk("mr_wdata",      {16'd0, wb_wdata},  32'h5555);

      // Back-to-back write then read
      mon_en = 1'b1;
      mem_memrw = 2'b10; mem_memaddr = 16'h0005; mem_memdata = 16'hA5A5;
      tick();
      chk("bb_wr_we_n", {31'd0, ram_we_n}, 32'd0);
      mem_memrw = 2'b01; mem_memaddr = 16'h0006; ram_din = 16'h0F0F;
      tick();   // WR second cycle
      tick();   // DONE
      chk("bb_done_ce_n", {31'd0, ram_ce_n}, 32'd1);
      tick();   // IDLE, read request pending
      chk("bb_idle_ce_n",  {31'd0, ram_ce_n},  32'd1);
      chk("bb_idle_stall", {31'd0, stall_req}, 32'd1);
      tick();   // RD first cycle
      chk("bb_rd_addr", {16'd0, ram_addr}, 32'h6);
      chk("bb_rd_oe_n", {31'd0, ram_oe_n}, 32'd0);
      tick();   // RD second cycle
      tick();   // DONE
      chk("bb_rdd_wdata", {16'd0, wb_wdata}, 32'h0F0F);
      mem_memrw = 2'b00;
      tick();
      tick();
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
